// File: rtl/rom_load_ctrl_if.sv
// HPS ioctl download stream in, Omega core ROM/PROM write ports and load status out.
// The controller sits on the slave modport; the HPS side (or a bench) uses master.
interface rom_load_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        cpu_we;
    logic        gfx_we;
    logic        prom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_count;
    logic [7:0]  checksum;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_we, gfx_we, prom_we, rom_addr, rom_data,
        input  core_reset, load_done, load_err, byte_count, checksum
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_we, gfx_we, prom_we, rom_addr, rom_data,
        output core_reset, load_done, load_err, byte_count, checksum
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: decodes the ioctl stream into CPU/GFX/PROM write strobes and holds
// the core in reset until a valid image is in. Define ROM_CHECKSUM_EN to also verify EXP_SUM.
module rom_load_ctrl #(
    parameter int unsigned CPU_SIZE  = 16384,
    parameter int unsigned GFX_SIZE  = 4096,
    parameter int unsigned PROM_SIZE = 32,
    parameter int unsigned RST_HOLD  = 16
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [7:0]  EXP_SUM   = 8'h00
`endif
) (
    input  logic           clk_sys,
    input  logic           reset,
    rom_load_ctrl_if.slave bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StCheck  = 3'd2;
    localparam logic [2:0] StSettle = 3'd3;
    localparam logic [2:0] StRun    = 3'd4;
    localparam logic [2:0] StError  = 3'd5;

    localparam logic [24:0] GFX_BASE  = 25'(CPU_SIZE);
    localparam logic [24:0] PROM_BASE = 25'(CPU_SIZE + GFX_SIZE);
    localparam logic [24:0] END_ADDR  = 25'(CPU_SIZE + GFX_SIZE + PROM_SIZE);
    localparam logic [15:0] GFX_OFF   = 16'(CPU_SIZE);
    localparam logic [15:0] PROM_OFF  = 16'(CPU_SIZE + GFX_SIZE);
    localparam logic [16:0] TOTAL     = 17'(CPU_SIZE + GFX_SIZE + PROM_SIZE);
    localparam int unsigned CNT_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RST_HOLD - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [16:0]      count_q, count_d, count_base;
    logic             range_q, range_d;
    logic             cpu_we_q, gfx_we_q, prom_we_q;
    logic [15:0]      rom_addr_q;
    logic [7:0]       rom_data_q;
    logic             core_reset_q, load_done_q, load_err_q;

    logic        entry, accept;
    logic        in_cpu, in_gfx, in_prom, in_range;
    logic [15:0] offset;
    logic        image_ok;

    // A rising download request from any other state restarts the load; that cycle's write counts.
    assign entry  = bus.ioctl_download && (state_q != StLoad);
    assign accept = bus.ioctl_wr && ((state_q == StLoad) || entry);

    always_comb begin
        in_range = bus.ioctl_addr < END_ADDR;
        in_cpu   = bus.ioctl_addr < GFX_BASE;
        in_gfx   = !in_cpu && (bus.ioctl_addr < PROM_BASE);
        in_prom  = (bus.ioctl_addr >= PROM_BASE) && in_range;
        if (in_cpu) begin
            offset = bus.ioctl_addr[15:0];
        end else if (in_gfx) begin
            offset = bus.ioctl_addr[15:0] - GFX_OFF;
        end else begin
            offset = bus.ioctl_addr[15:0] - PROM_OFF;
        end
    end

    always_comb begin
        count_base = entry ? '0 : count_q;
        count_d    = count_base;
        if (accept && in_range && (count_base != '1)) begin
            count_d = count_base + 17'd1;
        end
        range_d = (entry ? 1'b0 : range_q) | (accept && !in_range);
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = entry ? 8'h00 : sum_q;
        if (accept && in_range) begin
            sum_d = sum_d + bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign image_ok     = (count_q == TOTAL) && !range_q && (sum_q == EXP_SUM);
    assign bus.checksum = sum_q;
`else
    assign image_ok     = (count_q == TOTAL) && !range_q;
    assign bus.checksum = 8'h00;
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (entry) begin
            state_d = StLoad;
        end else begin
            case (state_q)
                StLoad: begin
                    if (!bus.ioctl_download) state_d = StCheck;
                end
                StCheck: begin
                    settle_d = '0;
                    state_d  = image_ok ? StSettle : StError;
                end
                StSettle: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = StRun;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                StIdle, StRun, StError: state_d = state_q;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            count_q      <= '0;
            range_q      <= 1'b0;
            cpu_we_q     <= 1'b0;
            gfx_we_q     <= 1'b0;
            prom_we_q    <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            count_q   <= count_d;
            range_q   <= range_d;
            cpu_we_q  <= accept && in_cpu;
            gfx_we_q  <= accept && in_gfx;
            prom_we_q <= accept && in_prom;
            if (accept && in_range) begin
                rom_addr_q <= offset;
                rom_data_q <= bus.ioctl_dout;
            end
            // Derived from next state so the core is released exactly on RUN entry.
            core_reset_q <= (state_d != StRun);
            load_done_q  <= (state_d == StRun);
            load_err_q   <= (state_d == StError);
        end
    end

    assign bus.cpu_we     = cpu_we_q;
    assign bus.gfx_we     = gfx_we_q;
    assign bus.prom_we    = prom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_data   = rom_data_q;
    assign bus.core_reset = core_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.byte_count = count_q;

endmodule
